// File: rtl/regfile_wb_arbiter_if.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Bundles the register-file write-port arbitration signals between the
// pipeline (WB stage + multi-cycle unit) and regfile_wb_arbiter.
//
// Signals:
//   wb_we, wb_reg[4:0], wb_data[31:0]      WB stage write request
//   mdu_valid, mdu_reg[4:0], mdu_data[31:0] MDU result offer
//   mdu_ready                               arbiter accepts an MDU result
//   RegWrite, WriteReg[4:0], WriteData[31:0] register file write port
//   busy_mask[31:0]                         registers with a queued MDU write
//   pipe_stall                              WB must be re-presented next cycle
//
// Modports:
//   master : pipeline / register-file side (drives requests)
//   slave  : arbiter side
// ----------------------------------------------------------------------------
interface regfile_wb_arbiter_if;
    logic        wb_we;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_reg;
    logic [31:0] mdu_data;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [31:0] busy_mask;
    logic        pipe_stall;

    modport master (
        output wb_we, wb_reg, wb_data, mdu_valid, mdu_reg, mdu_data,
        input  mdu_ready, RegWrite, WriteReg, WriteData, busy_mask, pipe_stall
    );

    modport slave (
        input  wb_we, wb_reg, wb_data, mdu_valid, mdu_reg, mdu_data,
        output mdu_ready, RegWrite, WriteReg, WriteData, busy_mask, pipe_stall
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter
// Arbitrates the single register-file write port between the pipeline WB
// stage and a multi-cycle unit (MDU). MDU results wait in a 2-entry FIFO;
// WB normally wins, and the FIFO head is written whenever WB is idle.
// A WB write to register r kills every queued (older) MDU result for r so
// the architectural order of writes is preserved.
//
// Optional feature (macro REGARB_STARVE_GUARD_EN):
//   starvation guard - after STARVE_LIMIT cycles of a valid head waiting,
//   the head is forced out, WB is suppressed and pipe_stall asks the
//   pipeline to re-present its WB request. Without the macro pipe_stall is 0.
//
// Parameters:
//   STARVE_LIMIT  1..15, waiting cycles before the head is forced (default 3)
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    regfile_wb_arbiter_if.slave (WB request, MDU handshake,
//          register-file write port, busy_mask, pipe_stall)
// ----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus
);

    if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_limit
        $error("regfile_wb_arbiter: STARVE_LIMIT must be in 1..15");
    end

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_WB,
        SRC_HEAD
    } src_e;

    // FIFO storage; slots outside the occupied window always have valid = 0
    logic [1:0]  valid_q, valid_d;
    logic [4:0]  reg_q  [2];
    logic [4:0]  reg_d  [2];
    logic [31:0] data_q [2];
    logic [31:0] data_d [2];
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  count_q, count_d;

    logic        ready;
    logic        wb_act;
    logic        head_valid;
    logic        head_dead;
    logic        force_head;
    logic        push;
    logic        pop;
    logic [31:0] busy;
    src_e        src;

    always_comb begin
        ready      = (count_q < 2'd2) && !reset;
        wb_act     = bus.wb_we && (bus.wb_reg != 5'd0);
        head_valid = (count_q != 2'd0) &&  valid_q[rd_ptr_q];
        // A head killed by an earlier WB write is silently retired
        head_dead  = (count_q != 2'd0) && !valid_q[rd_ptr_q];
    end

`ifdef REGARB_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

    logic [3:0] starve_q, starve_d;

    always_comb begin
        force_head = head_valid && (starve_q == LIMIT);
    end

    // Counts cycles a live head is passed over; any cycle without a live
    // head, or with the head written, restarts the count.
    always_comb begin
        starve_d = '0;
        if (head_valid && (src != SRC_HEAD)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    always_comb begin
        force_head = 1'b0;
    end
`endif

    // Write-port source selection
    always_comb begin
        src = SRC_NONE;
        if (force_head) begin
            src = SRC_HEAD;
        end else if (wb_act) begin
            src = SRC_WB;
        end else if (head_valid) begin
            src = SRC_HEAD;
        end
    end

    // Outputs; everything is held quiet while reset is asserted
    always_comb begin
        bus.RegWrite  = 1'b0;
        bus.WriteReg  = '0;
        bus.WriteData = '0;
        if (!reset) begin
            unique case (src)
                SRC_WB: begin
                    bus.RegWrite  = 1'b1;
                    bus.WriteReg  = bus.wb_reg;
                    bus.WriteData = bus.wb_data;
                end
                SRC_HEAD: begin
                    bus.RegWrite  = 1'b1;
                    bus.WriteReg  = reg_q[rd_ptr_q];
                    bus.WriteData = data_q[rd_ptr_q];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            if (valid_q[1'(i)]) begin
                busy[reg_q[1'(i)]] = 1'b1;
            end
        end
        busy[0] = 1'b0;
        bus.busy_mask  = reset ? '0 : busy;
        bus.pipe_stall = force_head && !reset;
        bus.mdu_ready  = ready;
    end

    // FIFO next state. Order matters: invalidation of older entries first,
    // then the dequeue, then the enqueue, so a result accepted in the same
    // cycle as a WB write to its register survives.
    always_comb begin
        valid_d  = valid_q;
        reg_d    = reg_q;
        data_d   = data_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;

        // r0 results are accepted but never stored
        push = bus.mdu_valid && ready && (bus.mdu_reg != 5'd0);
        pop  = head_dead || (src == SRC_HEAD);

        if (src == SRC_WB) begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (reg_q[1'(i)] == bus.wb_reg) begin
                    valid_d[1'(i)] = 1'b0;
                end
            end
        end

        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = ~rd_ptr_q;
        end

        if (push) begin
            valid_d[wr_ptr_q] = 1'b1;
            reg_d[wr_ptr_q]   = bus.mdu_reg;
            data_d[wr_ptr_q]  = bus.mdu_data;
            wr_ptr_d          = ~wr_ptr_q;
        end

        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= '0;
            reg_q    <= '{default: '0};
            data_q   <= '{default: '0};
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            reg_q    <= reg_d;
            data_q   <= data_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Clock and reset SHALL be one clock, `clk`, and one synchronous, active-high reset, `reset`; nothing else is asynchronous.
REQ-002 Parameter STARVE_LIMIT, default 3: number of consecutive cycles the queue head may wait before it forces a write; range 1..15.
REQ-003 Port `clk`, input, 1: rising-edge clock.
REQ-004 Port `reset`, input, 1: synchronous, active-high reset.
REQ-005 Port `wb_we`, input, 1: write request from the pipeline WB stage.
REQ-006 Port `wb_reg`, input, 5: WB destination register.
REQ-007 Port `wb_data`, input, 32: WB write data.
REQ-008 Port `mdu_valid`, input, 1: multi-cycle unit result valid.
REQ-009 Port `mdu_ready`, output, 1: arbiter can accept an MDU result.
REQ-010 Port `mdu_reg`, input, 5: MDU destination register.
REQ-011 Port `mdu_data`, input, 32: MDU result.
REQ-012 Port `RegWrite`, output, 1: register file write enable.
REQ-013 Port `WriteReg`, output, 5: register file write address.
REQ-014 Port `WriteData`, output, 32: register file write data.
REQ-015 Port `busy_mask`, output, 32: bit r = 1 while a queued MDU write targets register r.
REQ-016 Port `pipe_stall`, output, 1: pipeline must hold WB and re-present the same request next cycle.

Function
REQ-017 The block SHALL hold a 2-entry FIFO of {reg, data} for MDU results.
REQ-018 Ready rule: `mdu_ready` SHALL = (count < 2) && !reset, derived from registered count only. A full queue draining in the same cycle SHALL still show not-ready.
REQ-019 Enqueue: mdu_valid && mdu_ready SHALL enqueue at the next edge. A transfer with mdu_reg == 0 SHALL be accepted and discarded.
REQ-020 Write port: RegWrite/WriteReg/WriteData SHALL be combinational from the current inputs and registered state.
REQ-021 Normal priority: if wb_we && wb_reg != 0 and no force is active, WB SHALL win. Otherwise, if the queue is non-empty, the head SHALL be written and dequeued.
REQ-022 Idle: with nothing to write, RegWrite = 0, WriteReg = 0, WriteData = 0. A WB write to register 0 SHALL never assert RegWrite.
REQ-023 MDU latency: minimum 1 cycle from acceptance to RegWrite. There is no same-cycle bypass.
REQ-024 Ordering: when WB writes register r, every queued entry with reg == r SHALL be invalidated at that edge. An invalidated head SHALL be dropped without asserting RegWrite and frees its slot.
REQ-025 Self-conflict: an entry enqueued in the same cycle as a WB write to the same register SHALL NOT be invalidated (the MDU result is younger).
REQ-026 busy_mask SHALL be the OR of the one-hot reg fields of valid entries. Bit 0 SHALL always be 0.
REQ-027 Order: entries SHALL leave in arrival order. Count SHALL never exceed 2 or underflow.

Reset
REQ-028 While `reset` is high at a rising edge, count, entry valids, pointers and the starvation counter SHALL clear to 0.
REQ-029 During and immediately after reset: RegWrite = 0, busy_mask = 0, pipe_stall = 0, and mdu_ready = 0 (mdu_ready returns to 1 the cycle after reset deasserts).
REQ-030 Reset mid-operation SHALL discard queued entries without writing them.

Configuration
REQ-031 Macro REGARB_STARVE_GUARD_EN SHALL select the starvation guard.
REQ-032 Defined: a counter SHALL increment each cycle a valid head exists but is not written, and clear when the head is written or the queue empties.
REQ-033 Defined: when the counter == STARVE_LIMIT, in that cycle:
- the head SHALL be written;
- pipe_stall SHALL = 1;
- the WB write SHALL be suppressed;
- invalidation per REQ-024 SHALL NOT occur;
- the counter SHALL clear.
REQ-034 Not defined: no counter SHALL exist, pipe_stall SHALL be tied 0, and WB SHALL always win per REQ-021.

Verification
REQ-035 Reset, then MDU result to r5 = 0x1234 with WB idle -> next cycle RegWrite = 1, WriteReg = 5, WriteData = 0x1234; busy_mask[5] high for exactly 1 cycle.
REQ-036 Enqueue r3 = 0xA and r4 = 0xB back-to-back while WB writes r7 every cycle -> mdu_ready = 0 after the second; a third valid is held off; with the guard off, neither is written until wb_we drops; then r3 then r4 on consecutive cycles.
REQ-037 Queue r9 = 0xDEAD, then WB writes r9 = 0xBEEF -> entry invalidated; busy_mask[9] = 0; r9 is never written with 0xDEAD.
REQ-038 MDU result to r0 plus WB write to r0 -> RegWrite stays 0; busy_mask stays 0; mdu_ready unaffected.
REQ-039 With REGARB_STARVE_GUARD_EN and STARVE_LIMIT = 3: queue r2 = 0x55 with WB writing r8 continuously -> on the 4th waiting cycle pipe_stall = 1, WriteReg = 2, WriteData = 0x55; WB r8 re-presented and written the following cycle.
REQ-040 Assert reset with 2 entries queued -> no RegWrite; after release, busy_mask = 0 and mdu_ready = 1.
